// File: rtl/constant_capture_pkg.sv
// ============================================================================
//  Module      : constant_capture_pkg
//  Description : Shared state encoding and widths for constant_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package constant_capture_pkg;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      SETTLING = 2'd1,
      STABLE   = 2'd2
   } state_e;

   localparam int SETTLE_COUNT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/constant_capture_saturating_counter.sv
// ============================================================================
//  Module      : constant_capture_saturating_counter
//  Description : Width-parameterised up-counter that sticks at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module constant_capture_saturating_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             inc_en,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (inc_en && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/constant_capture.sv
// ============================================================================
//  Module      : constant_capture
//  Description : Latches one handshaked word and presents it as a settled
//                constant. Optional macro CONSTANT_CAPTURE_PARITY_EN adds a
//                stored parity bit and a sticky parity_error output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module constant_capture
   import constant_capture_pkg::*;
#(
   parameter int                  WORD_WIDTH         = 16,
   parameter logic [WORD_WIDTH-1:0] RESET_VALUE      = '0,
   parameter int                  SETTLE_CYCLES      = 4,
   parameter int                  REJECT_COUNT_WIDTH = 8
) (
   input  logic                          clock,
   input  logic                          clear,
   input  logic                          write_valid,
   output logic                          write_ready,
   input  logic [WORD_WIDTH-1:0]         write_data,
   input  logic                          release_pulse,
`ifdef CONSTANT_CAPTURE_PARITY_EN
   output logic                          parity_error,
`endif
   output logic [WORD_WIDTH-1:0]         constant_out,
   output logic                          constant_valid,
   output logic [REJECT_COUNT_WIDTH-1:0] reject_count
);

   localparam logic [SETTLE_COUNT_WIDTH-1:0] SETTLE_LOAD = SETTLE_COUNT_WIDTH'(SETTLE_CYCLES - 1);

   state_e                        state_d, state_q;
   logic [WORD_WIDTH-1:0]         word_d, word_q;
   logic [SETTLE_COUNT_WIDTH-1:0] settle_d, settle_q;
   logic                          ready_d, ready_q;
   logic                          valid_d, valid_q;
   logic                          held;
   logic                          reject_inc;
   logic                          perr_d;

   assign held       = (state_q == SETTLING) || (state_q == STABLE);
   assign reject_inc = write_valid && held;

`ifdef CONSTANT_CAPTURE_PARITY_EN
   logic parity_d, parity_q;
   logic perr_q;

   always_comb begin
      parity_d = parity_q;
      if ((state_q == EMPTY) && write_valid) begin
         parity_d = ^write_data;
      end
      perr_d = perr_q;
      if (release_pulse) begin
         perr_d = 1'b0;
      end else if (held && ((^word_q) != parity_q)) begin
         perr_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         parity_q <= ^RESET_VALUE;
         perr_q   <= 1'b0;
      end else begin
         parity_q <= parity_d;
         perr_q   <= perr_d;
      end
   end

   assign parity_error = perr_q;
`else
   assign perr_d = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      settle_d = settle_q;
      case (state_q)
         EMPTY: begin
            if (write_valid) begin
               word_d   = write_data;
               settle_d = SETTLE_LOAD;
               state_d  = SETTLING;
            end
         end
         SETTLING: begin
            if (release_pulse) begin
               state_d = EMPTY;
            end else if (settle_q == '0) begin
               state_d = STABLE;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         STABLE: begin
            if (release_pulse) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Handshake and qualifier flops follow the next state so they are pure registers.
      ready_d = (state_d == EMPTY);
      valid_d = (state_d == STABLE) && !perr_d;
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q  <= EMPTY;
         word_q   <= RESET_VALUE;
         settle_q <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         settle_q <= settle_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
      end
   end

   constant_capture_saturating_counter #(
      .WIDTH (REJECT_COUNT_WIDTH)
   ) u_reject_counter (
      .clock  (clock),
      .clear  (clear),
      .inc_en (reject_inc),
      .count  (reject_count)
   );

   assign write_ready    = ready_q;
   assign constant_out   = word_q;
   assign constant_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_constant_capture.sv
// ============================================================================
//  Module      : tb_constant_capture
//  Description : Scoreboard bench for constant_capture against a cycle-count
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_constant_capture;

   localparam int          WW  = 16;
   localparam logic [15:0] RV  = 16'hA5A5;
   localparam int          SC  = 4;
   localparam int          RCW = 8;
   localparam int          RC_MAX = 255;

   logic          clock = 1'b0;
   logic          clear = 1'b1;
   logic          write_valid = 1'b0;
   logic          release_pulse = 1'b0;
   logic [15:0]   write_data = 16'h0;
   logic          write_ready;
   logic [15:0]   constant_out;
   logic          constant_valid;
   logic [7:0]    reject_count;
`ifdef CONSTANT_CAPTURE_PARITY_EN
   logic          parity_error;
`endif

   always #5 clock = ~clock;

   constant_capture #(
      .WORD_WIDTH         (WW),
      .RESET_VALUE        (RV),
      .SETTLE_CYCLES      (SC),
      .REJECT_COUNT_WIDTH (RCW)
   ) dut (
      .clock          (clock),
      .clear          (clear),
      .write_valid    (write_valid),
      .write_ready    (write_ready),
      .write_data     (write_data),
      .release_pulse  (release_pulse),
`ifdef CONSTANT_CAPTURE_PARITY_EN
      .parity_error   (parity_error),
`endif
      .constant_out   (constant_out),
      .constant_valid (constant_valid),
      .reject_count   (reject_count)
   );

   typedef struct packed {
      logic [15:0] out;
      logic        valid;
      logic        ready;
      logic [7:0]  rc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e;
   int          n_cmp = 0;
   int          n_bad = 0;

   // Reference model: "held" plus the number of edges since capture.
   bit          m_held = 1'b0;
   int          m_since = 0;
   logic [15:0] m_word = RV;
   int          m_rc = 0;

   task automatic step(input bit clr, input bit wv, input logic [15:0] wd,
                       input bit rel, input bit push = 1'b1);
      exp_t x;
      @(negedge clock);
      clear = clr; write_valid = wv; write_data = wd; release_pulse = rel;
      if (clr) begin
         m_held = 1'b0; m_word = RV; m_rc = 0; m_since = 0;
      end else if (m_held) begin
         if (wv) m_rc = (m_rc >= RC_MAX) ? RC_MAX : m_rc + 1;
         if (rel) m_held = 1'b0;
         else     m_since = m_since + 1;
      end else if (wv) begin
         m_held = 1'b1; m_word = wd; m_since = 0;
      end
      x.out   = m_word;
      x.valid = m_held && (m_since >= SC);
      x.ready = !m_held;
      x.rc    = 8'(m_rc);
      if (push) sb_q.push_back(x);
   endtask

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ((constant_out !== e.out) || (constant_valid !== e.valid) ||
                (write_ready !== e.ready) || (reject_count !== e.rc)) begin
               n_bad++;
               $display("FAIL outputs @%0t: got out=%h valid=%b ready=%b rc=%0d, expected out=%h valid=%b ready=%b rc=%0d",
                        $time, constant_out, constant_valid, write_ready, reject_count,
                        e.out, e.valid, e.ready, e.rc);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step(1, 0, 16'h0, 0);
      repeat (7) step(0, 0, 16'($urandom), 0);
      step(0, 1, 16'h1234, 0);
      repeat (6) step(0, 0, 16'($urandom), 0);
      repeat (300) step(0, 1, 16'($urandom), 0);
      step(0, 1, 16'hDEAD, 1);
      step(0, 1, 16'hBEEF, 0);
      repeat (6) step(0, 0, 16'h0, 0);
      step(0, 0, 16'h0, 1);
      step(0, 1, 16'h5555, 0);
      repeat (2) step(0, 0, 16'h0, 0);
      step(1, 0, 16'h0, 0);
      repeat (6) step(0, 0, 16'h0, 0);
      step(0, 1, 16'h0F0F, 1);
      repeat (5) step(0, 0, 16'h0, 0);

`ifdef CONSTANT_CAPTURE_PARITY_EN
      begin
         logic [15:0] flipped;
         @(posedge clock); #2;
         flipped = dut.word_q ^ 16'h0010;
         force dut.word_q = flipped;
         @(posedge clock); #1;
         n_cmp++;
         if (parity_error !== 1'b1 || constant_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_set: got perr=%b valid=%b, expected perr=1 valid=0", parity_error, constant_valid);
         end
         release dut.word_q;
         step(0, 0, 16'h0, 0, 1'b0);
         @(posedge clock); #1;
         n_cmp++;
         if (parity_error !== 1'b1 || constant_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_sticky: got perr=%b valid=%b, expected perr=1 valid=0", parity_error, constant_valid);
         end
         step(0, 0, 16'h0, 1, 1'b0);
         @(posedge clock); #1;
         n_cmp++;
         if (parity_error !== 1'b0 || constant_valid !== 1'b0 || write_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL parity_release: got perr=%b valid=%b ready=%b, expected perr=0 valid=0 ready=1",
                     parity_error, constant_valid, write_ready);
         end
         step(1, 0, 16'h0, 0);
      end
`endif

      for (int i = 0; i < 600; i++) begin
         step(($urandom % 50) == 0, ($urandom % 3) == 0, 16'($urandom), ($urandom % 12) == 0);
      end

      @(posedge clock); #2;
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
